// File: rtl/button_event_scheduler.sv
// button_event_scheduler: debounces N_BTN raw pushbuttons against one shared sample tick, turns
//   each debounced press into a pending event and offers events one at a time, round-robin.
// Ports: clk_in, rst_n (async, active-low); pb raw buttons; btn_level debounced levels; tick
//   sample strobe; evt_valid/evt_ready/evt_id event handshake; overrun lost-press pulse.
// Latency: pb->btn_level 2 cycles + STABLE_CNT..STABLE_CNT+1 ticks; btn_level rise->evt_valid 2 cycles.
// Backpressure: evt_valid/evt_id held until accepted; a press on a button whose event is already
//   pending is dropped and reported on overrun.
// Optional: define BTN_AUTOREPEAT_EN for an auto-repeat event every REPEAT_TK ticks while held.
module button_event_scheduler #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 500_000,
    parameter int STABLE_CNT = 3,
    parameter int REPEAT_TK  = 20
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic [N_BTN-1:0]           pb,
    output logic [N_BTN-1:0]           btn_level,
    output logic                       tick,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(N_BTN)-1:0]   evt_id,
    output logic                       overrun
);

    localparam int IDW = $clog2(N_BTN);
    localparam int PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW  = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // Elaboration-time guard against unusable parameter sets.
    if (N_BTN < 2 || TICK_DIV < 2 || STABLE_CNT < 1 || REPEAT_TK < 1) begin : g_bad_param
        $error("button_event_scheduler: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Sample-tick prescaler. tick is registered so that it is high exactly
    // while the counter holds TICK_DIV-1.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;

    always_comb begin
        presc_nxt = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc_nxt;
            tick  <= (presc_nxt == PRESC_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers; nothing downstream touches raw pb.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: on each tick, count consecutive samples that disagree with
    // the current level; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [CW-1:0]    db_cnt     [N_BTN];
    logic [CW-1:0]    db_cnt_nxt [N_BTN];
    logic [N_BTN-1:0] level_nxt;

    always_comb begin
        level_nxt = btn_level;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_nxt[i] = db_cnt[i];
            if (tick) begin
                if (sync2[i] == btn_level[i]) begin
                    db_cnt_nxt[i] = '0;
                end else if (db_cnt[i] == CW'(STABLE_CNT - 1)) begin
                    level_nxt[i]  = sync2[i];
                    db_cnt_nxt[i] = '0;
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_level <= level_nxt;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Press detection (0->1 of the debounced level). Releases are ignored.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] evt_set;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= '0;
        end else begin
            level_d <= btn_level;
        end
    end

    always_comb begin
        rise = btn_level & ~level_d;
    end

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat: count ticks while a button stays pressed. The count only
    // advances when the level is 1 now and stays 1 at this tick, so a repeat
    // can never be raised on the same tick that the button is released.
    // rep_hit is registered so a repeat reaches pending with the same
    // one-cycle delay as a press, keeping the repeat period exact.
    localparam int RW = $clog2(REPEAT_TK + 1);

    logic [RW-1:0]    rep_cnt [N_BTN];
    logic [N_BTN-1:0] rep_hit;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rep_hit <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            rep_hit <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_level[i] || !level_nxt[i]) begin
                    rep_cnt[i] <= '0;
                end else if (tick) begin
                    if (rep_cnt[i] == RW'(REPEAT_TK - 1)) begin
                        rep_cnt[i] <= '0;
                        rep_hit[i] <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + RW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        evt_set = rise | rep_hit;
    end
`else
    always_comb begin
        evt_set = rise;
    end
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: first pending bit after last_grant, wrapping.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] pending;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   scan;
    logic             pick_vld;

    always_comb begin
        pick     = '0;
        scan     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N_BTN; k++) begin
            scan = IDW'((int'(last_grant) + k) % N_BTN);
            if (!pick_vld && pending[scan]) begin
                pick_vld = 1'b1;
                pick     = scan;
            end
        end
    end

    // ------------------------------------------------------------------
    // Offer FSM. IDLE: nothing offered. OFFER: evt_id held until accepted;
    // on acceptance the next winner is loaded in the same cycle.
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             valid_nxt;
    logic [IDW-1:0]   id_nxt;
    logic [IDW-1:0]   lg_nxt;
    logic [N_BTN-1:0] clr;
    logic [N_BTN-1:0] pending_nxt;
    logic             grant;
    logic             ovr_nxt;

    always_comb begin
        state_nxt = state;
        valid_nxt = evt_valid;
        id_nxt    = evt_id;
        lg_nxt    = last_grant;
        clr       = '0;
        grant     = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    grant = 1'b1;
                end
            end
            S_OFFER: begin
                if (evt_ready) begin
                    if (pick_vld) begin
                        grant = 1'b1;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        if (grant) begin
            state_nxt = S_OFFER;
            valid_nxt = 1'b1;
            id_nxt    = pick;
            lg_nxt    = pick;
            clr[pick] = 1'b1;
        end

        // A new press on the bit being granted this cycle re-arms it
        // (set wins) and is not counted as lost.
        pending_nxt = (pending & ~clr) | evt_set;
        ovr_nxt     = |(evt_set & pending & ~clr);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= IDW'(N_BTN - 1);
            pending    <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            evt_valid  <= valid_nxt;
            evt_id     <= id_nxt;
            last_grant <= lg_nxt;
            pending    <= pending_nxt;
            overrun    <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: self-checking bench for button_event_scheduler
//   (N_BTN=4, TICK_DIV=4, STABLE_CNT=3, REPEAT_TK=5).
// Expected event ids are queued when buttons are pressed and popped on each handshake.
module tb_button_event_scheduler;

    localparam int N_BTN      = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;
    localparam int REPEAT_TK  = 5;

    logic       clk_in    = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] pb        = '0;
    logic       evt_ready = 1'b0;
    logic [3:0] btn_level;
    logic       tick;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    time        evt_time[$];
    int         ovr_cnt  = 0;
    int         rise0_cnt = 0;
    int         evt_cnt  = 0;
    logic       sb_en    = 1'b1;
    logic [3:0] lvl_prev = '0;

    always #5 clk_in = ~clk_in;

    button_event_scheduler #(
        .N_BTN      (N_BTN),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT),
        .REPEAT_TK  (REPEAT_TK)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .pb        (pb),
        .btn_level (btn_level),
        .tick      (tick),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (btn_level[0] === 1'b1 && lvl_prev[0] === 1'b0) rise0_cnt++;
        lvl_prev = btn_level;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            evt_cnt++;
            evt_time.push_back($time);
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_unexpected actual_id=%0d expected=no_event", evt_id);
                end else begin
                    chk("evt_id", 32'(evt_id), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_level(input logic [3:0] mask, input string name, output int n);
        n = 0;
        while (btn_level !== mask && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, 32'(btn_level), 32'(mask));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_btn_level"}, 32'(btn_level), 0);
        chk({tag, "_tick"},      32'(tick), 0);
        chk({tag, "_evt_valid"}, 32'(evt_valid), 0);
        chk({tag, "_evt_id"},    32'(evt_id), 0);
        chk({tag, "_overrun"},   32'(overrun), 0);
    endtask

    // Call right after releasing reset at posedge+1: the counter is 0 at the
    // first falling edge, so tick is seen at every 4th falling edge.
    task automatic chk_tick_phase();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            chk("tick_phase", 32'(tick), 32'(k % 4 == 0));
        end
    endtask

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] n;
        logic [7:0] ids;   // id j in ids[2*j +: 2], in grant order
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   n;
        int   burst;
        int   ovr_base;
        int   evt_base;
        int   rise_base;

        // Round-robin order follows last_grant across entries (starts at 3).
        tbl[0] = '{4'b1011, 3'd3, {2'd0, 2'd3, 2'd1, 2'd0}};
        tbl[1] = '{4'b0011, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[2] = '{4'b0100, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[3] = '{4'b1111, 3'd4, {2'd2, 2'd1, 2'd0, 2'd3}};
        tbl[4] = '{4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[5] = '{4'b0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};

        // Reset state
        #23;
        chk_all_zero("reset");
        drive_edge();
        rst_n = 1'b1;
        chk_tick_phase();

`ifndef BTN_AUTOREPEAT_EN
        // Table: simultaneous presses, round-robin order, back-to-back offers
        drive_edge();
        evt_ready = 1'b1;
        ovr_base  = ovr_cnt;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < int'(tbl[e].n); j++) begin
                exp_q.push_back(tbl[e].ids[2*j +: 2]);
            end
            drive_edge();
            pb = tbl[e].mask;
            wait_level(tbl[e].mask, "press_level", n);
            chk("press_latency_ok", 32'(n <= 18), 1);
            n = 0;
            while (evt_valid !== 1'b1 && n < 10) begin
                @(negedge clk_in);
                n++;
            end
            chk("evt_valid_rise", 32'(evt_valid), 1);
            burst = 0;
            while (evt_valid === 1'b1 && burst < 8) begin
                burst++;
                @(negedge clk_in);
            end
            chk("burst_len", 32'(burst), 32'(tbl[e].n));
            drive_edge();
            pb = '0;
            wait_level(4'b0000, "release_level", n);
            repeat (8) @(negedge clk_in);
            chk("queue_drained", 32'(exp_q.size()), 0);
        end
        chk("table_no_overrun", 32'(ovr_cnt - ovr_base), 0);

        // Bounce on pb[0]: toggle every 3 cycles for 40 cycles, then hold 1
        rise_base = rise0_cnt;
        exp_q.push_back(2'd0);
        for (int i = 0; i < 40; i++) begin
            drive_edge();
            if (i % 3 == 0) pb[0] = ~pb[0];
        end
        drive_edge();
        pb[0] = 1'b1;
        wait_level(4'b0001, "bounce_level", n);
        repeat (30) @(negedge clk_in);
        chk("bounce_single_rise", 32'(rise0_cnt - rise_base), 1);
        chk("bounce_single_event", 32'(exp_q.size()), 0);
        drive_edge();
        pb = '0;
        wait_level(4'b0000, "bounce_release", n);
        repeat (8) @(negedge clk_in);

        // Backpressure: three presses of pb[1] while not ready
        drive_edge();
        evt_ready = 1'b0;
        ovr_base  = ovr_cnt;
        evt_base  = evt_cnt;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        for (int p = 0; p < 3; p++) begin
            drive_edge();
            pb[1] = 1'b1;
            wait_level(4'b0010, "ovr_press_level", n);
            repeat (4) @(negedge clk_in);
            chk("ovr_valid_held", 32'(evt_valid), 1);
            chk("ovr_id_held", 32'(evt_id), 1);
            drive_edge();
            pb[1] = 1'b0;
            wait_level(4'b0000, "ovr_release_level", n);
            repeat (4) @(negedge clk_in);
        end
        chk("ovr_pulses", 32'(ovr_cnt - ovr_base), 1);
        chk("ovr_no_accept_while_busy", 32'(evt_cnt - evt_base), 0);
        drive_edge();
        evt_ready = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("ovr_events_after_ready", 32'(evt_cnt - evt_base), 2);
        chk("ovr_queue_drained", 32'(exp_q.size()), 0);
        chk("ovr_valid_low", 32'(evt_valid), 0);

        // Reset mid-offer: event dropped, no replay
        drive_edge();
        evt_ready = 1'b0;
        pb[3]     = 1'b1;
        exp_q.push_back(2'd3);
        wait_level(4'b1000, "rst_press_level", n);
        repeat (4) @(negedge clk_in);
        chk("rst_pre_valid", 32'(evt_valid), 1);
        chk("rst_pre_id", 32'(evt_id), 3);
        @(posedge clk_in);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        pb        = '0;
        evt_ready = 1'b1;
        evt_base  = evt_cnt;
        repeat (3) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        chk_tick_phase();
        repeat (40) @(negedge clk_in);
        chk("rst_no_replay", 32'(evt_cnt - evt_base), 0);
`else
        // Auto-repeat: hold pb[3] for 30 ticks with ready high
        begin
            time fall_t;
            int  base;
            int  evt_at_fall;
            sb_en = 1'b0;
            drive_edge();
            evt_ready = 1'b1;
            base = evt_time.size();
            pb[3] = 1'b1;
            wait_level(4'b1000, "rep_press_level", n);
            repeat (120 - n) @(posedge clk_in);
            #1;
            pb[3] = 1'b0;
            wait_level(4'b0000, "rep_release_level", n);
            fall_t      = $time;
            evt_at_fall = evt_time.size();
            chk("rep_count_min", 32'((evt_time.size() - base) >= 6), 1);
            for (int i = base + 1; i < evt_time.size(); i++) begin
                chk("rep_interval", 32'(evt_time[i] - evt_time[i-1]), 200);
            end
            if (evt_time.size() > base) begin
                chk("rep_before_release", 32'(evt_time[evt_time.size()-1] < fall_t), 1);
            end
            repeat (60) @(negedge clk_in);
            chk("rep_none_after_release", 32'(evt_time.size() - evt_at_fall), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
